// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
//   op_t        : operation select (add / subtract)
//   signed_ovf  : two's complement overflow from the carries around the MSB
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Overflow occurs when the carry into the sign bit differs from the carry out of it.
  function automatic logic signed_ovf(input logic c_msb, input logic c_out);
    return c_msb ^ c_out;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder, one slice of the pipelined adder.
//   a, b   : CHUNK-bit operand slices
//   c_in   : carry into bit 0
//   s      : CHUNK-bit sum slice
//   c_out  : carry out of the top bit
//   c_msb  : carry into the top bit (for signed overflow on the last slice)
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb
);

  logic [CHUNK:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = w_c[CHUNK];
  assign c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream handshake.
// One CHUNK-bit slice is added per stage; the carry is registered between stages.
//   clk, reset          : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake for a, b, c_in, sub
//   a, b                : WIDTH-bit operands
//   c_in                : carry in (ignored when sub=1)
//   sub                 : 0 -> a+b+c_in, 1 -> a-b
//   out_valid/out_ready : output handshake for s, c_out, ovf
//   s, c_out, ovf       : registered result, carry out of MSB, signed overflow
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned STAGES     = (WIDTH / CHUNK_SAFE == 0) ? 1 : WIDTH / CHUNK_SAFE;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK_SAFE) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             w_adv;
  op_t              w_op;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  assign w_op    = sub ? OP_SUB : OP_ADD;
  assign w_b_eff = (w_op == OP_SUB) ? ~b : b;
  assign w_cin0  = (w_op == OP_SUB) ? 1'b1 : c_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * CHUNK;
    localparam int unsigned HI = LO + CHUNK - 1;

    logic             w_src_vld;
    logic             w_ci;
    logic             w_co;
    logic             w_cm;
    logic [CHUNK-1:0] w_as;
    logic [CHUNK-1:0] w_bs;
    logic [CHUNK-1:0] w_sum;
    logic [HI:0]      w_s_next;

    logic             r_vld;
    logic             r_c;
    logic [HI:0]      r_s;

    if (k == 0) begin : g_first
      // Stage 0 adds straight from the ports so STAGES=1 is a single registered adder.
      assign w_src_vld = in_valid;
      assign w_ci      = w_cin0;
      assign w_as      = a[HI:LO];
      assign w_bs      = w_b_eff[HI:LO];
      assign w_s_next  = w_sum;
    end else begin : g_later
      assign w_src_vld = g_stage[k-1].r_vld;
      assign w_ci      = g_stage[k-1].r_c;
      assign w_as      = g_stage[k-1].g_ops.r_a[HI:LO];
      assign w_bs      = g_stage[k-1].g_ops.r_b[HI:LO];
      assign w_s_next  = {w_sum, g_stage[k-1].r_s};
    end

    chunk_adder #(
      .CHUNK (CHUNK)
    ) u_chunk_adder (
      .a     (w_as),
      .b     (w_bs),
      .c_in  (w_ci),
      .s     (w_sum),
      .c_out (w_co),
      .c_msb (w_cm)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_c   <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_vld <= w_src_vld;
        // Data only moves with a valid op, so s holds the last result between ops.
        if (w_src_vld) begin
          r_c <= w_co;
          r_s <= w_s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      // Operand slices not yet consumed travel alongside the carry.
      logic [WIDTH-1:HI+1] w_a_rest;
      logic [WIDTH-1:HI+1] w_b_rest;
      logic [WIDTH-1:HI+1] r_a;
      logic [WIDTH-1:HI+1] r_b;
      logic                w_c_msb_unused;

      assign w_c_msb_unused = w_cm;

      if (k == 0) begin : g_src_port
        assign w_a_rest = a[WIDTH-1:HI+1];
        assign w_b_rest = w_b_eff[WIDTH-1:HI+1];
      end else begin : g_src_prev
        assign w_a_rest = g_stage[k-1].g_ops.r_a[WIDTH-1:HI+1];
        assign w_b_rest = g_stage[k-1].g_ops.r_b[WIDTH-1:HI+1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_src_vld) begin
          r_a <= w_a_rest;
          r_b <= w_b_rest;
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_src_vld) begin
          r_ovf <= signed_ovf(w_cm, w_co);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign s         = g_stage[STAGES-1].r_s;
  assign c_out     = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
module tb_pipelined_addsub;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sb;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s;
  logic        c_out;
  logic        ovf;

  logic        in_ready1;
  logic        out_valid1;
  logic [15:0] s1;
  logic        c_out1;
  logic        ovf1;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  res_t q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  pipelined_addsub #(
    .WIDTH (16),
    .CHUNK (4)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  pipelined_addsub #(
    .WIDTH (16),
    .CHUNK (16)
  ) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .s         (s1),
    .c_out     (c_out1),
    .ovf       (ovf1)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                  input logic rci, input logic rsub);
    res_t r;
    int   ua, ub, sa, sb, sum_u, sum_s;
    ua = int'(ra);
    ub = int'(rb);
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rsub) begin
      sum_u = ua - ub;
      sum_s = sa - sb;
      r.c   = (ua >= ub);
    end else begin
      sum_u = ua + ub + int'(rci);
      sum_s = sa + sb + int'(rci);
      r.c   = (sum_u > 65535);
    end
    r.s = sum_u[15:0];
    r.o = (sum_s > 32767) || (sum_s < -32768);
    return r;
  endfunction

  // Scoreboard for the CHUNK=4 instance: every accepted op must come out once, in order.
  always @(negedge clk) begin
    res_t e;
    if (reset) begin
      q.delete();
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else if (out_ready) begin
          e = q.pop_front();
          chk("sb_s", s, e.s);
          chk("sb_c_out", c_out, e.c);
          chk("sb_ovf", ovf, e.o);
          n_out++;
        end
      end
      if (in_valid && in_ready) q.push_back(ref_op(a, b, c_in, sub));
    end
  end

  // Single op on an idle pipeline; checks latency and result of the chosen instance.
  task automatic apply_vec(input vec_t v, input int dut, input int lat_exp);
    int   lat;
    logic ov;
    a         = v.a;
    b         = v.b;
    c_in      = v.ci;
    sub       = v.sb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    lat       = 0;
    do begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      ov = (dut == 0) ? out_valid : out_valid1;
    end while (!ov && lat < 20);
    chk("vec_latency", lat, lat_exp);
    if (dut == 0) begin
      chk("vec_s", s, v.s);
      chk("vec_c_out", c_out, v.c);
      chk("vec_ovf", ovf, v.o);
    end else begin
      chk("vec1_s", s1, v.s);
      chk("vec1_c_out", c_out1, v.c);
      chk("vec1_ovf", ovf1, v.o);
    end
  endtask

  task automatic drain();
    int cnt;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt       = 0;
    while ((q.size() != 0 || out_valid) && cnt < 50) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int          sent, cyc, base;
    logic        took;
    logic [15:0] held_s;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_s", s, 16'h0000);
    chk("rst_c_out", c_out, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, latency 4.
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], 0, 4);
    drain();

    // Eight back-to-back random ops with a three-cycle output stall.
    base     = n_out;
    sent     = 0;
    cyc      = 0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    c_in     = 1'($urandom);
    sub      = 1'($urandom);
    in_valid = 1'b1;
    held_s   = '0;
    while (sent < 8 && cyc < 100) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      @(negedge clk);
      took = in_valid && in_ready;
      if (cyc >= 5 && cyc < 8) begin
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        if (cyc == 5) held_s = s;
        else chk("stall_s_stable", s, held_s);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        sent++;
        if (sent < 8) begin
          a    = 16'($urandom);
          b    = 16'($urandom);
          c_in = 1'($urandom);
          sub  = 1'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("stream_sent", sent, 8);
    drain();
    chk("stream_results", n_out - base, 8);

    // Longer random traffic with random backpressure.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      c_in      = 1'($urandom);
      sub       = 1'($urandom);
      @(posedge clk);
      #1;
    end
    drain();

    // Reset with three ops in flight: nothing may emerge afterwards.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a        = 16'($urandom);
      b        = 16'($urandom);
      sub      = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_s", s, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", out_valid, 1'b0);
    end

    // CHUNK=16 instance: single registered adder.
    apply_vec(vecs[0], 1, 1);
    apply_vec(vecs[2], 1, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
